// File: rtl/scv_pkg.sv
// rtl/scv_pkg.sv - shared SCV types and region indices for the ROM-init loader
package scv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rominit_state_t;

  localparam int ROMINIT_REGION_BOOT = 0;
  localparam int ROMINIT_REGION_CHR  = 1;
  localparam int ROMINIT_REGION_CART = 2;

endpackage

// File: rtl/rominit_fifo.sv
// rtl/rominit_fifo.sv - synchronous byte FIFO with a registered output stage
// count includes the output register; full refers to the storage array only.
module rominit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int MW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [MW-1:0]    mem_cnt;
  logic             out_valid;
  logic             wr_en;
  logic             load_out;

  assign full     = (mem_cnt == MW'(DEPTH));
  assign empty    = !out_valid;
  assign count    = CW'(mem_cnt) + CW'(out_valid);
  assign wr_en    = push && !full;
  // Refill the output register whenever it is free or being consumed this cycle.
  assign load_out = (mem_cnt != '0) && (!out_valid || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (wr_en && !load_out) mem_cnt <= mem_cnt + MW'(1);
      else if (!wr_en && load_out) mem_cnt <= mem_cnt - MW'(1);
      if (load_out) begin
        dout      <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rominit_loader.sv
// rtl/rominit_loader.sv - host download stream to one-hot ROMINIT bus with size guard
// Optional CKSUM adder built only when ROMINIT_CHECKSUM_EN is defined.
module rominit_loader
  import scv_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_W = 25,
  parameter int REGION_AW [NUM_REGIONS] = '{12, 13, 17},
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   CLK,
  input  logic                   RESB,
  input  logic                   DL_START,
  input  logic [IDX_W-1:0]       DL_IDX,
  input  logic                   DL_WR,
  input  logic [7:0]             DL_DATA,
  input  logic                   DL_END,
  output logic                   DL_WAIT,
  output logic [NUM_REGIONS-1:0] ROMINIT_SEL,
  output logic [ADDR_W-1:0]      ROMINIT_ADDR,
  output logic [7:0]             ROMINIT_DATA,
  output logic                   ROMINIT_VALID,
  input  logic                   ROMINIT_READY,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR_OVF,
  output logic [ADDR_W:0]        LEN,
  output logic [15:0]            CKSUM
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 2;

  rominit_state_t    state, state_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  limit;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              done_q;
  logic              start;
  logic              accept;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [CW-1:0]     fifo_count;

  assign start    = (state == IDLE) && DL_START;
  assign DL_WAIT  = (state == LOAD) && fifo_full;
  assign accept   = (state == LOAD) && DL_WR && !DL_WAIT;
  // An out-of-range index leaves limit at 0, so every byte is dropped.
  assign push     = accept && (len_q < limit);
  assign fifo_pop = ROMINIT_VALID && ROMINIT_READY;

  assign ROMINIT_VALID = !fifo_empty;
  assign ROMINIT_ADDR  = addr_q;
  assign BUSY          = (state != IDLE);
  assign DONE          = done_q;
  assign ERR_OVF       = err_q;
  assign LEN           = len_q;

  always_comb begin
    limit       = '0;
    ROMINIT_SEL = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (int'(idx_q) == i) begin
        limit          = LEN_W'(1) << REGION_AW[i];
        ROMINIT_SEL[i] = (state != IDLE);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (DL_START) state_nxt = LOAD;
      LOAD:    if (DL_END) state_nxt = DRAIN;
      DRAIN:   if (fifo_count == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state  <= IDLE;
      idx_q  <= '0;
      len_q  <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == FIN);
      if (start) begin
        idx_q  <= DL_IDX;
        len_q  <= '0;
        addr_q <= '0;
        err_q  <= 1'b0;
      end else begin
        if (push) len_q <= len_q + LEN_W'(1);
        if (accept && !push) err_q <= 1'b1;
        if (fifo_pop) addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

`ifdef ROMINIT_CHECKSUM_EN
  logic [15:0] cksum_q;

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) cksum_q <= '0;
    else if (start) cksum_q <= '0;
    else if (push) cksum_q <= cksum_q + {8'h00, DL_DATA};
  end

  assign CKSUM = cksum_q;
`else
  assign CKSUM = '0;
`endif

  rominit_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESB),
    .push  (push),
    .din   (DL_DATA),
    .pop   (fifo_pop),
    .dout  (ROMINIT_DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_rominit_loader.sv
// tb/tb_rominit_loader.sv - scoreboard bench for rominit_loader
module tb_rominit_loader;
  import scv_pkg::*;

  logic        CLK = 1'b0;
  logic        RESB = 1'b0;
  logic        DL_START = 1'b0;
  logic [1:0]  DL_IDX = 2'd0;
  logic        DL_WR = 1'b0;
  logic [7:0]  DL_DATA = 8'd0;
  logic        DL_END = 1'b0;
  logic        ROMINIT_READY = 1'b1;
  logic        DL_WAIT;
  logic [2:0]  ROMINIT_SEL;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic        BUSY;
  logic        DONE;
  logic        ERR_OVF;
  logic [25:0] LEN;
  logic [15:0] CKSUM;

  typedef struct packed {
    logic [2:0]  sel;
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  bit   wait_seen = 0;
  int   ready_mode = 0;
  int   rdy_cyc = 0;
  int   m_idx = 0;
  int   m_len = 0;
  bit   m_err = 0;
  int   tb_aw[3] = '{12, 13, 17};
  bit   hold_pend = 0;
  logic [32:0] hold_val;

`ifdef ROMINIT_CHECKSUM_EN
  localparam logic [15:0] EXP_CKSUM = 16'h0088;
`else
  localparam logic [15:0] EXP_CKSUM = 16'h0000;
`endif

  rominit_loader dut (
    .CLK           (CLK),
    .RESB          (RESB),
    .DL_START      (DL_START),
    .DL_IDX        (DL_IDX),
    .DL_WR         (DL_WR),
    .DL_DATA       (DL_DATA),
    .DL_END        (DL_END),
    .DL_WAIT       (DL_WAIT),
    .ROMINIT_SEL   (ROMINIT_SEL),
    .ROMINIT_ADDR  (ROMINIT_ADDR),
    .ROMINIT_DATA  (ROMINIT_DATA),
    .ROMINIT_VALID (ROMINIT_VALID),
    .ROMINIT_READY (ROMINIT_READY),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERR_OVF       (ERR_OVF),
    .LEN           (LEN),
    .CKSUM         (CKSUM)
  );

  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      rdy_cyc++;
      ROMINIT_READY = (ready_mode == 0) ? 1'b1 : ((rdy_cyc % 3) == 0);
    end
  end

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge CLK) begin
    if (!RESB) begin
      hold_pend = 0;
    end else begin
      if (DONE) done_cnt++;
      if (DL_WAIT) wait_seen = 1;
      if (hold_pend && ROMINIT_VALID) begin
        checks++;
        if ({ROMINIT_ADDR, ROMINIT_DATA} !== hold_val) begin
          failures++;
          $display("FAIL hold_stable got=%h exp=%h", {ROMINIT_ADDR, ROMINIT_DATA}, hold_val);
        end
      end
      hold_pend = ROMINIT_VALID && !ROMINIT_READY;
      hold_val  = {ROMINIT_ADDR, ROMINIT_DATA};
      if (ROMINIT_VALID && ROMINIT_READY) begin
        exp_t e;
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL hs_unexpected got sel=%b addr=%0d data=%h exp none", ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA);
        end else begin
          e = exp_q.pop_front();
          if ({ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA} !== e) begin
            failures++;
            $display("FAIL hs_data got sel=%b addr=%0d data=%h exp sel=%b addr=%0d data=%h",
                     ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, e.sel, e.addr, e.data);
          end
        end
      end
    end
  end

  function automatic int region_limit(input int idx);
    return (idx < 3) ? (1 << tb_aw[idx]) : 0;
  endfunction

  task automatic start_load(input int idx);
    DL_IDX = 2'(idx);
    DL_START = 1'b1;
    @(posedge CLK);
    #1;
    DL_START = 1'b0;
    m_idx = idx;
    m_len = 0;
    m_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit with_end);
    bit ok = 0;
    DL_WR = 1'b1;
    DL_DATA = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge CLK);
      if (!DL_WAIT) begin
        ok = 1;
        DL_END = with_end;
        if (m_len < region_limit(m_idx)) begin
          exp_q.push_back({3'(1 << m_idx), 25'(m_len), d});
          m_len++;
        end else begin
          m_err = 1;
        end
      end
      @(posedge CLK);
      #1;
    end
    DL_END = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout got=waiting exp=accepted");
    end
  endtask

  task automatic end_load();
    DL_WR = 1'b0;
    DL_END = 1'b1;
    @(posedge CLK);
    #1;
    DL_END = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge CLK);
      if (DONE) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout got=no_done exp=done");
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESB = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({ROMINIT_SEL, ROMINIT_VALID, ROMINIT_ADDR, ROMINIT_DATA} !== '0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {ROMINIT_SEL, ROMINIT_VALID, ROMINIT_ADDR, ROMINIT_DATA});
    end
    checks++;
    if ({BUSY, DONE, ERR_OVF, LEN, DL_WAIT, CKSUM} !== '0) begin
      failures++;
      $display("FAIL reset_status got=%h exp=0", {BUSY, DONE, ERR_OVF, LEN, DL_WAIT, CKSUM});
    end
    RESB = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic_load();
    int h0 = hs_cnt;
    int d0 = done_cnt;
    ready_mode = 0;
    start_load(ROMINIT_REGION_BOOT);
    checks++;
    if ({ROMINIT_SEL, BUSY} !== 4'b0011) begin
      failures++;
      $display("FAIL basic_sel got=%b exp=0011", {ROMINIT_SEL, BUSY});
    end
    for (int i = 0; i < 4096; i++) send_byte(8'(i), i == 4095);
    DL_WR = 1'b0;
    wait_done(100);
    checks++;
    if (hs_cnt - h0 !== 4096) begin failures++; $display("FAIL basic_hs got=%0d exp=4096", hs_cnt - h0); end
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (LEN !== 26'd4096) begin failures++; $display("FAIL basic_len got=%0d exp=4096", LEN); end
    checks++;
    if (ERR_OVF !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", ERR_OVF); end
    checks++;
    if ({ROMINIT_SEL, BUSY} !== 4'b0000) begin failures++; $display("FAIL basic_idle got=%b exp=0000", {ROMINIT_SEL, BUSY}); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL basic_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int h0 = hs_cnt;
    ready_mode = 1;
    wait_seen = 0;
    start_load(ROMINIT_REGION_CHR);
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0);
    end_load();
    wait_done(1000);
    ready_mode = 0;
    checks++;
    if (wait_seen !== 1'b1) begin failures++; $display("FAIL bp_wait got=%b exp=1", wait_seen); end
    checks++;
    if (hs_cnt - h0 !== 64) begin failures++; $display("FAIL bp_hs got=%0d exp=64", hs_cnt - h0); end
    checks++;
    if (LEN !== 26'd64) begin failures++; $display("FAIL bp_len got=%0d exp=64", LEN); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    int h0 = hs_cnt;
    start_load(ROMINIT_REGION_BOOT);
    for (int i = 0; i < 4100; i++) send_byte(8'(i * 7), 1'b0);
    end_load();
    wait_done(100);
    checks++;
    if (hs_cnt - h0 !== 4096) begin failures++; $display("FAIL ovf_hs got=%0d exp=4096", hs_cnt - h0); end
    checks++;
    if (ERR_OVF !== m_err) begin failures++; $display("FAIL ovf_err got=%b exp=%b", ERR_OVF, m_err); end
    checks++;
    if (LEN !== 26'd4096) begin failures++; $display("FAIL ovf_len got=%0d exp=4096", LEN); end
  endtask

  task automatic test_midload_reset();
    int h0;
    start_load(ROMINIT_REGION_CART);
    checks++;
    if (ERR_OVF !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ERR_OVF); end
    for (int i = 0; i < 100; i++) send_byte(8'(i + 3), 1'b0);
    @(posedge CLK);
    #3;
    RESB = 1'b0;
    #1;
    checks++;
    if ({ROMINIT_SEL, ROMINIT_VALID, ROMINIT_ADDR, ROMINIT_DATA, BUSY, DONE, ERR_OVF, LEN, DL_WAIT, CKSUM} !== '0) begin
      failures++;
      $display("FAIL rst_async got=%h exp=0",
               {ROMINIT_SEL, ROMINIT_VALID, ROMINIT_ADDR, ROMINIT_DATA, BUSY, DONE, ERR_OVF, LEN, DL_WAIT, CKSUM});
    end
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESB = 1'b1;
    h0 = hs_cnt;
    DL_WR = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    DL_WR = 1'b0;
    checks++;
    if ({BUSY, 32'(hs_cnt - h0)} !== 33'd0) begin
      failures++;
      $display("FAIL rst_idle got busy=%b hs=%0d exp busy=0 hs=0", BUSY, hs_cnt - h0);
    end
    start_load(ROMINIT_REGION_CART);
    checks++;
    if (ROMINIT_SEL !== 3'b100) begin failures++; $display("FAIL rst_sel got=%b exp=100", ROMINIT_SEL); end
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b0);
    end_load();
    wait_done(100);
    checks++;
    if (hs_cnt - h0 !== 8) begin failures++; $display("FAIL rst_hs got=%0d exp=8", hs_cnt - h0); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL rst_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_invalid_idx();
    int h0 = hs_cnt;
    int d0 = done_cnt;
    start_load(3);
    checks++;
    if ({ROMINIT_SEL, BUSY} !== 4'b0001) begin failures++; $display("FAIL inv_sel got=%b exp=0001", {ROMINIT_SEL, BUSY}); end
    for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b0);
    end_load();
    wait_done(100);
    checks++;
    if (hs_cnt - h0 !== 0) begin failures++; $display("FAIL inv_hs got=%0d exp=0", hs_cnt - h0); end
    checks++;
    if (ERR_OVF !== 1'b1) begin failures++; $display("FAIL inv_err got=%b exp=1", ERR_OVF); end
    checks++;
    if (LEN !== 26'd0) begin failures++; $display("FAIL inv_len got=%0d exp=0", LEN); end
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL inv_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_restart_ignored();
    int h0 = hs_cnt;
    start_load(ROMINIT_REGION_CHR);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    DL_WR = 1'b0;
    DL_IDX = 2'd0;
    DL_START = 1'b1;
    @(posedge CLK);
    #1;
    DL_START = 1'b0;
    checks++;
    if (ROMINIT_SEL !== 3'b010) begin failures++; $display("FAIL restart_sel got=%b exp=010", ROMINIT_SEL); end
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    end_load();
    wait_done(100);
    checks++;
    if (LEN !== 26'd4) begin failures++; $display("FAIL restart_len got=%0d exp=4", LEN); end
    checks++;
    if (hs_cnt - h0 !== 4) begin failures++; $display("FAIL restart_hs got=%0d exp=4", hs_cnt - h0); end
  endtask

  task automatic test_checksum();
    start_load(ROMINIT_REGION_CHR);
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0);
    end_load();
    wait_done(100);
    checks++;
    if (CKSUM !== EXP_CKSUM) begin failures++; $display("FAIL cksum got=%h exp=%h", CKSUM, EXP_CKSUM); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL cksum_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_overflow();
    test_midload_reset();
    test_invalid_idx();
    test_restart_ignored();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rominit_loader.md
# rominit_loader

Streaming ROM-image loader between the host download port and the SCV core's ROM initialisation bus. It accepts a byte stream tagged with a region index. Each byte is buffered in a small FIFO and replayed onto the one-hot `ROMINIT_SEL`/`ADDR`/`DATA`/`VALID` bus with sink backpressure. It also counts bytes, guards each region's size and reports completion. It generalises the fixed three-region, no-backpressure boot/chr/cart load sequence to N parametrised regions with flow control and overflow detection.

## Interface
Parameters:
- `NUM_REGIONS`, default 3: number of ROM regions (boot, chr, cart).
- `ADDR_W`, default 25: ROMINIT address width.
- `REGION_AW`, int array[NUM_REGIONS], default '{12, 13, 17}: log2 of the maximum byte size of each region.
- `FIFO_DEPTH`, default 4: buffer depth; power of two, at least 2.

Ports:
- `CLK` in 1: system clock.
- `RESB` in 1: reset, asynchronous, active-low.
- `DL_START` in 1: one-cycle pulse that begins a download.
- `DL_IDX` in $clog2(NUM_REGIONS): region index, sampled on `DL_START`.
- `DL_WR` in 1: byte strobe.
- `DL_DATA` in 8: byte payload.
- `DL_END` in 1: one-cycle pulse that ends a download.
- `DL_WAIT` out 1: backpressure to the source.
- `ROMINIT_SEL` out NUM_REGIONS: one-hot region select.
- `ROMINIT_ADDR` out ADDR_W: byte address within the region.
- `ROMINIT_DATA` out 8: byte.
- `ROMINIT_VALID` out 1: byte present on the bus.
- `ROMINIT_READY` in 1: sink accepts the byte.
- `BUSY` out 1: high in any state except IDLE.
- `DONE` out 1: one-cycle pulse on completion.
- `ERR_OVF` out 1: sticky error flag; cleared on the next accepted `DL_START`.
- `LEN` out ADDR_W+1: bytes written by the last or current download.
- `CKSUM` out 16: additive checksum; present only with the macro, see Configuration.

## Operation
- **States:** IDLE, LOAD, DRAIN, FIN.
- **IDLE:**
  - `DL_START` moves to LOAD.
  - On that transition: latch `DL_IDX`, clear `LEN`, `ERR_OVF`, `CKSUM` and the address counter.
  - `DL_WR` is ignored in IDLE.
- **Byte acceptance:** in LOAD, a byte is accepted when `DL_WR=1` and `DL_WAIT=0` in the same cycle.
  - If `LEN < 2**REGION_AW[idx]`, the byte is pushed to the FIFO and `LEN` increments.
  - Otherwise the byte is dropped and `ERR_OVF` is set.
- **Invalid index:** if `idx >= NUM_REGIONS`, `ROMINIT_SEL` stays 0, every byte is dropped, and `ERR_OVF` is set on the first dropped byte.
- **LOAD exit:** `DL_END` moves to DRAIN.
  - A `DL_WR` in the same cycle as `DL_END` is still accepted.
- **DRAIN:** when the FIFO is empty and no output handshake is pending, move to FIN.
- **FIN:** `DONE=1` for one cycle, then IDLE.
- **Ignored restart:** `DL_START` in LOAD, DRAIN or FIN is ignored.
- **Output bus:**
  - Bytes are popped in order.
  - `ROMINIT_ADDR` starts at 0 and increments by 1 after each handshake (`VALID & READY`).
  - `ADDR` and `DATA` are held stable while `VALID & !READY`.
  - `ROMINIT_SEL` is one-hot for the latched idx during LOAD, DRAIN and FIN, and 0 in IDLE.
- **`DL_WAIT`:** equals FIFO full, and is only active in LOAD; it is 0 in other states.

## Timing
- **Reset:** every output resets to 0, and the state resets to IDLE, with the FIFO empty.
  - Reset takes effect asynchronously when `RESB` falls, including mid-load.
  - After reset, operation restarts only on a new `DL_START`.
- **Latency:** a byte accepted at edge N appears with `ROMINIT_VALID=1` after edge N+1 at the earliest.
- **Throughput:** 1 byte/cycle sustained when `ROMINIT_READY=1`.
- **Simultaneous push and pop when full:** the FIFO count stays unchanged, and `DL_WAIT` for the next cycle is computed from the registered count.
- **Outputs:** `LEN`, `ERR_OVF` and `DONE` are registered.
  - `DONE` rises at least one cycle after the final output handshake.
- **Arithmetic:** `ROMINIT_ADDR` does not wrap in practice, because the overflow guard caps it at `2**REGION_AW-1`.

## Configuration
- **`ROMINIT_CHECKSUM_EN` defined:** `CKSUM` is a 16-bit wrap-around sum of every byte that is pushed to the FIFO (dropped bytes excluded). It is cleared on `DL_START` and holds after FIN.
- **`ROMINIT_CHECKSUM_EN` undefined:** the port is still present, tied to 0, and no adder is built.

## Structure
- Shared package `scv_pkg` holds:
  - `rominit_state_t` (IDLE/LOAD/DRAIN/FIN);
  - `ROMINIT_REGION_BOOT=0`, `ROMINIT_REGION_CHR=1`, `ROMINIT_REGION_CART=2`.
- Sub-module `rominit_fifo`: synchronous FIFO.
  - Registered output, parametrised width and depth, async active-low reset.
  - Ports: push, pop, full, empty, count.

## Test plan
- **Basic load:** region 0, 4096 bytes with value addr[7:0], `READY=1` → `ADDR` 0..4095 in order, `SEL=3'b001`, `LEN=4096`, one `DONE` pulse, `ERR_OVF=0`.
- **Backpressure:** `DL_WR` every cycle, `READY` high 1 cycle in 3, `FIFO_DEPTH=4`, 64 bytes → `DL_WAIT` asserts; all 64 bytes arrive in order, with none lost or duplicated.
- **Overflow:** `REGION_AW[0]=12`, 4100 bytes → 4096 handshakes, `ERR_OVF=1`, `LEN=4096`.
- **Mid-load reset:** `RESB` low after byte 100 of region 2 → all outputs 0 immediately. A new load then starts at `ADDR=0` with `SEL=3'b100`.
- **Invalid index and ignored restart:**
  - `DL_IDX=3` with `NUM_REGIONS=3` → `SEL=0`, no `VALID`, `ERR_OVF=1`, `DONE` pulses.
  - `DL_START` issued during LOAD → ignored, and the latched idx is unchanged.
- **Checksum:** bytes 0x01..0x10 → `CKSUM=0x0088` with `ROMINIT_CHECKSUM_EN`, and 0 without it.
